// File: rtl/opb_register_simulink2ppc.sv
// OPB slave that publishes a fabric-side 32-bit value to the PowerPC. It holds a
// DATA/STATUS/CTRL register triplet with a capture counter and a freeze control.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  localparam int unused_params = C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [15:0] count_q, count_d;
  logic        new_q, new_d;
  logic        freeze_q, freeze_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;

  // Window test via borrow bits, so the bounds never fold into constant compares.
  logic [32:0] below_base;
  logic [32:0] above_high;
  logic        hit;
  logic [5:0]  reg_sel;

  assign below_base = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
  assign above_high = {1'b0, C_HIGHADDR} - {1'b0, OPB_ABus};
  assign hit        = OPB_select && !below_base[32] && !above_high[32];
  assign reg_sel    = OPB_ABus[24:29];

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    count_d  = count_q;
    new_d    = new_q;
    freeze_d = freeze_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = ACK;
          rdata_d = '0;
          if (OPB_RNW) begin
            case (reg_sel)
              6'd0: rdata_d = data_q;
              6'd1: begin
                rdata_d = {new_q, 15'd0, count_q};
                new_d   = 1'b0;
              end
              6'd2:    rdata_d = {31'd0, freeze_q};
              default: rdata_d = '0;
            endcase
          end else if (reg_sel == 6'd2 && OPB_BE[3]) begin
            freeze_d = OPB_DBus[31];
          end
        end
      end
      ACK: begin
        ack_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!OPB_select) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture comes last so it overrides a same-cycle NEW clear; it sees the old FREEZE.
    if (user_data_valid && !freeze_q) begin
      data_d  = user_data_in;
      count_d = count_q + 16'd1;
      new_d   = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      count_q  <= '0;
      new_q    <= 1'b0;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      count_q  <= count_d;
      new_q    <= new_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
    end
  end

  assign Sl_xferAck = ack_q;
  assign Sl_DBus    = ack_q ? rdata_q : 32'd0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30],
                       below_base[31:0], above_high[31:0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: bus reads/writes, capture, freeze,
// counter wrap and asynchronous reset in the middle of a transfer.
module tb_opb_register_simulink2ppc;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_data_valid;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  int          lat;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(user_data_in), .user_data_valid(user_data_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer starting at a negedge; lat = negedges until ack seen, -1 on timeout.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                      input logic [3:0] be, input logic vld, input logic [31:0] vdata,
                      output logic [31:0] rdata, output int lat_o);
    lat_o           = -1;
    rdata           = '0;
    OPB_ABus        = addr;
    OPB_RNW         = rnw;
    OPB_DBus        = wdata;
    OPB_BE          = be;
    OPB_select      = 1'b1;
    user_data_valid = vld;
    user_data_in    = vdata;
    for (int c = 1; c <= 8; c++) begin
      @(negedge OPB_Clk);
      user_data_valid = 1'b0;
      if (Sl_xferAck === 1'b1) begin
        lat_o = c;
        rdata = Sl_DBus;
        break;
      end
    end
    OPB_select = 1'b0;
    OPB_RNW    = 1'b0;
    OPB_DBus   = '0;
    if (lat_o > 0) begin
      @(negedge OPB_Clk);
      check("ack_one_cycle", {31'd0, Sl_xferAck}, 32'd0);
      check("dbus_zero_no_ack", Sl_DBus, 32'd0);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int l;
    xfer(addr, 1'b1, '0, 4'b1111, 1'b0, '0, d, l);
    check({tag, "_lat"}, l, 32'd2);
    check(tag, d, exp);
  endtask

  task automatic pulse(input logic [31:0] v);
    user_data_in    = v;
    user_data_valid = 1'b1;
    @(negedge OPB_Clk);
    user_data_valid = 1'b0;
  endtask

  initial begin
    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    check("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    check("rst_dbus", Sl_DBus, 32'd0);
    check("tieoffs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);

    // first read after reset, then basic capture and NEW clear-on-read
    rd_chk("data_after_rst", 32'h00, 32'h0000_0000);
    pulse(32'h1234_5678);
    rd_chk("data_cap", 32'h00, 32'h1234_5678);
    rd_chk("status1", 32'h04, 32'h8000_0001);
    rd_chk("status2", 32'h04, 32'h0000_0001);

    // capture on the hit-sampling edge: read shows old value, capture still lands
    pulse(32'hA5A5_A5A5);
    xfer(32'h04, 1'b1, '0, 4'b1111, 1'b1, 32'h0F0F_0F0F, rd, lat);
    check("status_same_edge", rd, 32'h8000_0002);
    rd_chk("status_new_kept", 32'h04, 32'h8000_0003);
    xfer(32'h00, 1'b1, '0, 4'b1111, 1'b1, 32'h3333_3333, rd, lat);
    check("data_same_edge", rd, 32'h0F0F_0F0F);
    rd_chk("data_after_same", 32'h00, 32'h3333_3333);

    // freeze
    xfer(32'h08, 1'b0, 32'h0000_0001, 4'b0001, 1'b0, '0, rd, lat);
    check("wr_lat", lat, 32'd2);
    rd_chk("ctrl_frozen", 32'h08, 32'h0000_0001);
    pulse(32'hDEAD_BEEF);
    rd_chk("data_frozen", 32'h00, 32'h3333_3333);
    rd_chk("status_frozen", 32'h04, 32'h8000_0004);
    xfer(32'h08, 1'b0, 32'h0000_0000, 4'b0001, 1'b0, '0, rd, lat);
    rd_chk("ctrl_unfrozen", 32'h08, 32'h0000_0000);
    xfer(32'h08, 1'b0, 32'h0000_0001, 4'b1110, 1'b0, '0, rd, lat);
    rd_chk("ctrl_be_masked", 32'h08, 32'h0000_0000);
    xfer(32'h08, 1'b0, 32'h0000_0001, 4'b0001, 1'b1, 32'h1111_1111, rd, lat);
    rd_chk("data_old_freeze", 32'h00, 32'h1111_1111);
    rd_chk("status_old_freeze", 32'h04, 32'h8000_0005);
    rd_chk("ctrl_set", 32'h08, 32'h0000_0001);

    // writes to read-only/unused offsets, unused read, out-of-window access
    xfer(32'h00, 1'b0, 32'hFFFF_FFFF, 4'b1111, 1'b0, '0, rd, lat);
    rd_chk("data_ro", 32'h00, 32'h1111_1111);
    rd_chk("unused_off", 32'h0C, 32'h0000_0000);
    xfer(32'h100, 1'b1, '0, 4'b1111, 1'b0, '0, rd, lat);
    check("no_hit_outside", lat, -32'sd1);
    @(negedge OPB_Clk);

    // reset asserted in the ACK-state cycle
    OPB_ABus = 32'h04; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b1;
    #1;
    check("rst_ack_state_ack", {31'd0, Sl_xferAck}, 32'd0);
    check("rst_ack_state_dbus", Sl_DBus, 32'd0);
    @(negedge OPB_Clk);
    check("rst_held_ack", {31'd0, Sl_xferAck}, 32'd0);
    OPB_select = 1'b0; OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    rd_chk("status_after_rst", 32'h04, 32'h0000_0000);
    rd_chk("data_after_rst2", 32'h00, 32'h0000_0000);
    rd_chk("ctrl_after_rst", 32'h08, 32'h0000_0000);

    // reset while acknowledge is high
    pulse(32'h0000_0055);
    OPB_ABus = 32'h00; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (2) @(negedge OPB_Clk);
    check("ack_high_before_rst", {31'd0, Sl_xferAck}, 32'd1);
    check("dbus_before_rst", Sl_DBus, 32'h0000_0055);
    OPB_Rst = 1'b1;
    #1;
    check("rst_async_ack", {31'd0, Sl_xferAck}, 32'd0);
    check("rst_async_dbus", Sl_DBus, 32'd0);
    @(negedge OPB_Clk);
    OPB_select = 1'b0; OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    rd_chk("data_after_rst3", 32'h00, 32'h0000_0000);

    // counter wrap: 65535 captures, then one more
    user_data_in    = 32'h0000_CAFE;
    user_data_valid = 1'b1;
    repeat (65535) @(negedge OPB_Clk);
    user_data_valid = 1'b0;
    rd_chk("status_ffff", 32'h04, 32'h8000_FFFF);
    pulse(32'hCAFE_0001);
    rd_chk("status_wrap", 32'h04, 32'h8000_0000);
    rd_chk("data_wrap", 32'h00, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
